// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency tagged data memory responder for a processor port.
// Optional address checking is enabled by defining DMEM_ERR_CHECK_EN.
module dmem_responder #(
  parameter int MEM_DEPTH_WORDS = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  proc2mem_command,
  input  logic [31:0] proc2mem_addr,
  input  logic [31:0] proc2mem_data,
  output logic        mem2proc_ready,
  output logic [3:0]  mem2proc_response,
  output logic [3:0]  mem2proc_tag,
  output logic [31:0] mem2proc_data,
  output logic        mem2proc_err
);
  localparam int IW = MEM_DEPTH_WORDS > 1 ? $clog2(MEM_DEPTH_WORDS) : 1;
  localparam logic [1:0] NONE = 2'b00, LOAD = 2'b01, STORE = 2'b10;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [3:0] cnt, tag_cnt, tag_q;
  logic [1:0] cmd_q;
  logic [31:0] addr_q, data_q;
  logic [31:0] mem [MEM_DEPTH_WORDS];
  logic accept, wr_en, src_err, err_q;
  logic [1:0] src_cmd;
  logic [29:0] src_word;
  logic [31:0] src_data;

  function automatic logic [IW-1:0] index(input logic [29:0] w);
    return IW'(w % 30'(MEM_DEPTH_WORDS));
  endfunction

  assign accept = rst_n && state == IDLE && (proc2mem_command == LOAD || proc2mem_command == STORE);
  // With LATENCY=1 the store is written on the accept edge, so it must come from the live inputs
  assign src_cmd  = state == IDLE ? proc2mem_command : cmd_q;
  assign src_word = state == IDLE ? proc2mem_addr[31:2] : addr_q[31:2];
  assign src_data = state == IDLE ? proc2mem_data : data_q;
`ifdef DMEM_ERR_CHECK_EN
  assign src_err = state == IDLE
    ? (proc2mem_addr[1:0] != 2'b00 || proc2mem_addr[31:2] >= 30'(MEM_DEPTH_WORDS))
    : (addr_q[1:0] != 2'b00 || addr_q[31:2] >= 30'(MEM_DEPTH_WORDS));
  assign err_q = addr_q[1:0] != 2'b00 || addr_q[31:2] >= 30'(MEM_DEPTH_WORDS);
`else
  logic unused_ok;
  assign unused_ok = &{1'b0, addr_q[1:0]};
  assign src_err = 1'b0;
  assign err_q = 1'b0;
`endif
  assign wr_en = rst_n && state_n == RESP && src_cmd == STORE && !src_err;

  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = accept ? (LATENCY == 1 ? RESP : WAIT) : IDLE;
    else if (state == WAIT) state_n = cnt == 4'd0 ? RESP : WAIT;
    else state_n = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= 4'd0;
      tag_cnt <= 4'd1;
      tag_q <= 4'd0;
      cmd_q <= NONE;
      addr_q <= 32'd0;
      data_q <= 32'd0;
    end else begin
      state <= state_n;
      if (accept) begin
        cnt <= LATENCY > 1 ? 4'(LATENCY - 2) : 4'd0;
        tag_cnt <= tag_cnt == 4'd15 ? 4'd1 : tag_cnt + 4'd1;
        tag_q <= tag_cnt;
        cmd_q <= proc2mem_command;
        addr_q <= proc2mem_addr;
        data_q <= proc2mem_data;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[index(src_word)] <= src_data;
  end

  assign mem2proc_ready    = state == IDLE;
  assign mem2proc_response = accept ? tag_cnt : 4'd0;
  assign mem2proc_tag      = state == RESP ? tag_q : 4'd0;
  assign mem2proc_data     = (state == RESP && cmd_q == LOAD && !err_q) ? mem[index(addr_q[31:2])] : 32'd0;
  assign mem2proc_err      = state == RESP && err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of dmem_responder at LATENCY=2, depth 1024.
module tb_dmem_responder;
  localparam logic [1:0] NONE = 2'b00, LOAD = 2'b01, STORE = 2'b10;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [1:0] cmd;
  logic [31:0] addr, wdata, rdata;
  logic ready, err;
  logic [3:0] resp, tag;
  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  dmem_responder #(.MEM_DEPTH_WORDS(1024), .LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n), .proc2mem_command(cmd), .proc2mem_addr(addr),
    .proc2mem_data(wdata), .mem2proc_ready(ready), .mem2proc_response(resp),
    .mem2proc_tag(tag), .mem2proc_data(rdata), .mem2proc_err(err)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // One full operation from an idle cycle; nc/na is what the initiator presents while busy
  task automatic op(input logic [1:0] c, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] er, input logic [31:0] ed, input logic ee,
                    input logic [1:0] nc, input logic [31:0] na);
    cmd = c; addr = a; wdata = d;
    @(negedge clk);
    chk("accept_ready", 32'(ready), 1);
    chk("accept_resp", 32'(resp), 32'(er));
    chk("accept_tag", 32'(tag), 0);
    @(posedge clk); #1 cmd = nc; addr = na;
    @(negedge clk);
    chk("wait_ready", 32'(ready), 0);
    chk("wait_resp", 32'(resp), 0);
    chk("wait_tag", 32'(tag), 0);
    chk("wait_data", rdata, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("resp_ready", 32'(ready), 0);
    chk("resp_resp", 32'(resp), 0);
    chk("resp_tag", 32'(tag), 32'(er));
    chk("resp_data", rdata, ed);
    chk("resp_err", 32'(err), 32'(ee));
    @(posedge clk); #1;
  endtask

  initial begin
    cmd = LOAD; addr = 32'h10; wdata = 32'h0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_resp", 32'(resp), 0);
    chk("rst_tag", 32'(tag), 0);
    chk("rst_data", rdata, 0);
    chk("rst_err", 32'(err), 0);
    @(posedge clk); #1 rst_n = 1'b1; cmd = NONE;
    op(STORE, 32'h10, 32'hDEADBEEF, 4'd1, 32'h0, 1'b0, LOAD, 32'h10);
    op(LOAD, 32'h10, 32'h0, 4'd2, 32'hDEADBEEF, 1'b0, NONE, 32'h0);
    op(STORE, 32'h0, 32'hCAFEF00D, 4'd3, 32'h0, 1'b0, NONE, 32'h0);
    op(STORE, 32'h20, 32'h11112222, 4'd4, 32'h0, 1'b0, NONE, 32'h0);
    cmd = 2'b11; addr = 32'h10;
    @(negedge clk);
    chk("rsvd_ready", 32'(ready), 1);
    chk("rsvd_resp", 32'(resp), 0);
    @(posedge clk); #1 cmd = NONE;
    @(negedge clk);
    chk("rsvd_next_ready", 32'(ready), 1);
    chk("rsvd_next_tag", 32'(tag), 0);
    @(posedge clk); #1;
    op(LOAD, 32'h20, 32'h0, 4'd5, 32'h11112222, 1'b0, NONE, 32'h0);
    cmd = STORE; addr = 32'h20; wdata = 32'h5A5A5A5A;
    @(negedge clk);
    chk("midrst_accept_resp", 32'(resp), 6);
    @(posedge clk); #1 cmd = NONE; rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_tag", 32'(tag), 0);
    chk("midrst_data", rdata, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_after_tag", 32'(tag), 0);
    chk("midrst_after_ready", 32'(ready), 1);
    @(posedge clk); #1;
    op(LOAD, 32'h20, 32'h0, 4'd1, 32'h11112222, 1'b0, NONE, 32'h0);
    rst_n = 1'b0; #2 rst_n = 1'b1;
    for (int i = 0; i < 16; i++)
      op(LOAD, 32'h10, 32'h0, 4'(i % 15 + 1), 32'hDEADBEEF, 1'b0, NONE, 32'h0);
`ifdef DMEM_ERR_CHECK_EN
    op(LOAD, 32'h1002, 32'h0, 4'd2, 32'h0, 1'b1, NONE, 32'h0);
    op(STORE, 32'h4000, 32'hBADBAD00, 4'd3, 32'h0, 1'b1, NONE, 32'h0);
    op(LOAD, 32'h0, 32'h0, 4'd4, 32'hCAFEF00D, 1'b0, NONE, 32'h0);
`else
    op(LOAD, 32'h1002, 32'h0, 4'd2, 32'hCAFEF00D, 1'b0, NONE, 32'h0);
    op(STORE, 32'h4000, 32'hBADBAD00, 4'd3, 32'h0, 1'b0, NONE, 32'h0);
    op(LOAD, 32'h0, 32'h0, 4'd4, 32'hBADBAD00, 1'b0, NONE, 32'h0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
